// File: rtl/otter_pkg.sv
// Shared types for the OTTER pipeline sequencing logic: opcode encodings,
// forwarding selects, interrupt-entry states and small hazard helpers.
package otter_pkg;

    // RV32I major opcodes recognised by the stage decoders
    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    // Operand source: register file, MEM-stage ALU result, WB write data
    typedef enum logic [1:0] {
        RF  = 2'd0,
        MEM = 2'd1,
        WB  = 2'd2
    } fwd_sel_t;

    // Interrupt-entry sequencing states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TAKE  = 2'd2
    } int_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Picks the operand source for one DEC source register. A MEM-stage
    // late producer has no result yet, so it falls through to WB.
    function automatic fwd_sel_t fwd_select(
        input logic       uses,
        input logic [4:0] src,
        input logic       mem_writes,
        input logic       mem_late,
        input logic [4:0] mem_rd,
        input logic       wb_writes,
        input logic [4:0] wb_rd
    );
        fwd_sel_t sel;
        sel = RF;
        if (uses) begin
            if (mem_writes && !mem_late && (mem_rd == src)) begin
                sel = MEM;
            end else if (wb_writes && (wb_rd == src)) begin
                sel = WB;
            end
        end
        return sel;
    endfunction

    // True when a DEC source cannot be satisfied this cycle: any writer in
    // EXE has not computed yet, and a late producer in MEM only has data at WB.
    function automatic logic src_hazard(
        input logic       uses,
        input logic [4:0] src,
        input logic       exe_writes,
        input logic [4:0] exe_rd,
        input logic       mem_late,
        input logic [4:0] mem_rd
    );
        logic hit;
        hit = 1'b0;
        if (uses) begin
            if (exe_writes && (exe_rd == src)) begin
                hit = 1'b1;
            end
            if (mem_late && (mem_rd == src)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/otter_ir_fields.sv
// Extracts register fields and read/write behaviour from one stage's IR.
// x0 is folded in here so callers never see a use or write of register 0.
import otter_pkg::*;

module otter_ir_fields (
    input  logic [31:0] ir,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        writes_rd,
    output logic        late_producer
);

    logic [2:0] func3;
    logic       rs1_read;
    logic       rs2_read;
    logic       rd_write;
    logic       is_late;
    logic       unused_bits;

    assign unused_bits = ^ir[31:25];

    // Opcode decode into operand usage, destination write and result timing
    always_comb begin
        rs1      = ir[19:15];
        rs2      = ir[24:20];
        rd       = ir[11:7];
        func3    = ir[14:12];
        rs1_read = 1'b0;
        rs2_read = 1'b0;
        rd_write = 1'b0;
        is_late  = 1'b0;
        case (ir[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rd_write = 1'b1;
            end
            OPC_JALR: begin
                rs1_read = 1'b1;
                rd_write = 1'b1;
            end
            OPC_BRANCH: begin
                rs1_read = 1'b1;
                rs2_read = 1'b1;
            end
            OPC_LOAD: begin
                rs1_read = 1'b1;
                rd_write = 1'b1;
                is_late  = 1'b1;
            end
            OPC_STORE: begin
                rs1_read = 1'b1;
                rs2_read = 1'b1;
            end
            OPC_OP_IMM: begin
                rs1_read = 1'b1;
                rd_write = 1'b1;
            end
            OPC_OP: begin
                rs1_read = 1'b1;
                rs2_read = 1'b1;
                rd_write = 1'b1;
            end
            OPC_SYSTEM: begin
                rs1_read = !func3[2];
                rd_write = (func3 != 3'd0);
                is_late  = 1'b1;
            end
            default: begin
                rs1_read = 1'b0;
            end
        endcase
        uses_rs1      = rs1_read && (rs1 != 5'd0);
        uses_rs2      = rs2_read && (rs2 != 5'd0);
        writes_rd     = rd_write && (rd != 5'd0);
        late_producer = writes_rd && is_late;
    end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage OTTER core: stage
// enables/flushes for load-use, redirects and memory wait, operand
// forwarding, interrupt-entry drain sequencing and a stall-cycle counter.
import otter_pkg::*;

module otter_hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      DEC_IR,
    input  logic [31:0]      EXE_IR,
    input  logic [31:0]      MEM_IR,
    input  logic [31:0]      WB_IR,
    input  logic             BR_TAKEN,
    input  logic             MEM_BUSY,
    input  logic             INTR,
    input  logic             MIE,
    output logic             PC_WE,
    output logic             DEC_WE,
    output logic             DEC_FLUSH,
    output logic             EXE_BUBBLE,
    output logic             PIPE_HOLD,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic             EPC_CAPTURE,
    output logic             INT_TAKEN,
    output logic [CNT_W-1:0] STALL_CYCLES
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_uses_rs1, dec_uses_rs2, dec_writes, dec_late;
    logic [4:0] exe_rs1, exe_rs2, exe_rd;
    logic       exe_uses_rs1, exe_uses_rs2, exe_writes, exe_late;
    logic [4:0] mem_rs1, mem_rs2, mem_rd;
    logic       mem_uses_rs1, mem_uses_rs2, mem_writes, mem_late;
    logic [4:0] wb_rs1, wb_rs2, wb_rd;
    logic       wb_uses_rs1, wb_uses_rs2, wb_writes, wb_late;

    int_state_t         state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               data_stall;
    logic               accept;
    fwd_sel_t           fwd_a_sel;
    fwd_sel_t           fwd_b_sel;
    logic               unused_fields;

    otter_ir_fields u_dec (
        .ir            (DEC_IR),
        .rs1           (dec_rs1),
        .rs2           (dec_rs2),
        .rd            (dec_rd),
        .uses_rs1      (dec_uses_rs1),
        .uses_rs2      (dec_uses_rs2),
        .writes_rd     (dec_writes),
        .late_producer (dec_late)
    );

    otter_ir_fields u_exe (
        .ir            (EXE_IR),
        .rs1           (exe_rs1),
        .rs2           (exe_rs2),
        .rd            (exe_rd),
        .uses_rs1      (exe_uses_rs1),
        .uses_rs2      (exe_uses_rs2),
        .writes_rd     (exe_writes),
        .late_producer (exe_late)
    );

    otter_ir_fields u_mem (
        .ir            (MEM_IR),
        .rs1           (mem_rs1),
        .rs2           (mem_rs2),
        .rd            (mem_rd),
        .uses_rs1      (mem_uses_rs1),
        .uses_rs2      (mem_uses_rs2),
        .writes_rd     (mem_writes),
        .late_producer (mem_late)
    );

    otter_ir_fields u_wb (
        .ir            (WB_IR),
        .rs1           (wb_rs1),
        .rs2           (wb_rs2),
        .rd            (wb_rd),
        .uses_rs1      (wb_uses_rs1),
        .uses_rs2      (wb_uses_rs2),
        .writes_rd     (wb_writes),
        .late_producer (wb_late)
    );

    // Decoder outputs that this controller has no use for in a given stage
    assign unused_fields = ^{dec_rd, dec_writes, dec_late,
                             exe_rs1, exe_rs2, exe_uses_rs1, exe_uses_rs2, exe_late,
                             mem_rs1, mem_rs2, mem_uses_rs1, mem_uses_rs2,
                             wb_rs1, wb_rs2, wb_uses_rs1, wb_uses_rs2, wb_late};

    // Hazard detection, forwarding selection and interrupt acceptance
    always_comb begin
        data_stall = src_hazard(dec_uses_rs1, dec_rs1, exe_writes, exe_rd, mem_late, mem_rd)
                   | src_hazard(dec_uses_rs2, dec_rs2, exe_writes, exe_rd, mem_late, mem_rd);
        fwd_a_sel  = fwd_select(dec_uses_rs1, dec_rs1, mem_writes, mem_late, mem_rd,
                                wb_writes, wb_rd);
        fwd_b_sel  = fwd_select(dec_uses_rs2, dec_rs2, mem_writes, mem_late, mem_rd,
                                wb_writes, wb_rd);
        accept     = (state == RUN) && INTR && MIE && !MEM_BUSY && !BR_TAKEN && !data_stall;
    end

    // Stage controls in priority order: reset, memory wait, interrupt entry, data stall, redirect
    always_comb begin
        PC_WE       = 1'b1;
        DEC_WE      = 1'b1;
        DEC_FLUSH   = 1'b0;
        EXE_BUBBLE  = 1'b0;
        PIPE_HOLD   = 1'b0;
        EPC_CAPTURE = 1'b0;
        INT_TAKEN   = 1'b0;
        FWD_A       = fwd_a_sel;
        FWD_B       = fwd_b_sel;
        if (!RST_N) begin
            PC_WE      = 1'b0;
            DEC_WE     = 1'b0;
            DEC_FLUSH  = 1'b1;
            EXE_BUBBLE = 1'b1;
            FWD_A      = RF;
            FWD_B      = RF;
        end else if (MEM_BUSY) begin
            PC_WE     = 1'b0;
            DEC_WE    = 1'b0;
            PIPE_HOLD = 1'b1;
        end else if (state == DRAIN) begin
            PC_WE      = 1'b0;
            DEC_WE     = 1'b0;
            DEC_FLUSH  = 1'b1;
            EXE_BUBBLE = 1'b1;
        end else if (state == TAKE) begin
            INT_TAKEN  = 1'b1;
            DEC_FLUSH  = 1'b1;
            EXE_BUBBLE = 1'b1;
        end else if (data_stall) begin
            PC_WE      = 1'b0;
            DEC_WE     = 1'b0;
            EXE_BUBBLE = 1'b1;
        end else if (BR_TAKEN) begin
            DEC_FLUSH = 1'b1;
        end else begin
            EPC_CAPTURE = accept;
        end
    end

    // Interrupt-entry FSM; everything holds while data memory is busy
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else if (!MEM_BUSY) begin
            case (state)
                RUN: begin
                    if (accept) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    if (drain_cnt <= DRAIN_W'(1)) begin
                        state <= TAKE;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                TAKE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is not advanced
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            STALL_CYCLES <= '0;
        end else if (!PC_WE && (STALL_CYCLES != {CNT_W{1'b1}})) begin
            STALL_CYCLES <= STALL_CYCLES + CNT_W'(1);
        end
    end

endmodule
